nes_pad_reader: RTL and testbench

Serial front end for the NES-style game pad. Polls the pad periodically with a latch pulse and eight clock pulses, shifts in the active-low button bits, and registers the 8-bit button vector. It also priority-encodes the vector into the 3-bit `val` code that feeds the seven-segment button display stage directly downstream.

---
 rtl/pad_pkg.sv | 34 +++
 rtl/nes_pad_reader_if.sv | 28 ++
 rtl/pad_sync.sv | 26 ++
 rtl/nes_pad_reader.sv | 156 +++++++++++++++
 tb/tb_nes_pad_reader.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/pad_pkg.sv
// Shared definitions for the NES pad reader and the downstream button display.
package pad_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StLatch,
    StRead,
    StDone
  } pad_state_e;

  // Bit positions in the button vector (pad shift order, A first)
  localparam int unsigned BTN_A      = 0;
  localparam int unsigned BTN_B      = 1;
  localparam int unsigned BTN_SELECT = 2;
  localparam int unsigned BTN_START  = 3;
  localparam int unsigned BTN_UP     = 4;
  localparam int unsigned BTN_DOWN   = 5;
  localparam int unsigned BTN_LEFT   = 6;
  localparam int unsigned BTN_RIGHT  = 7;

  // Display codes; Start deliberately has none
  localparam logic [2:0] VAL_NONE   = 3'd0;
  localparam logic [2:0] VAL_A      = 3'd1;
  localparam logic [2:0] VAL_B      = 3'd2;
  localparam logic [2:0] VAL_SELECT = 3'd3;
  localparam logic [2:0] VAL_UP     = 3'd4;
  localparam logic [2:0] VAL_DOWN   = 3'd5;
  localparam logic [2:0] VAL_LEFT   = 3'd6;
  localparam logic [2:0] VAL_RIGHT  = 3'd7;

  // Width of the shared phase/poll counter
  localparam int unsigned CntW = 16;

endpackage

// File: rtl/nes_pad_reader_if.sv
// Pad-side and result-side signals of the NES pad reader.
// master: the reader; slave: the pad plus the result consumer.
interface nes_pad_reader_if;
  logic       pad_data;
  logic       pad_latch;
  logic       pad_clk;
  logic [7:0] buttons;
  logic [2:0] val;
  logic       frame_valid;

  modport master (
    input  pad_data,
    output pad_latch,
    output pad_clk,
    output buttons,
    output val,
    output frame_valid
  );

  modport slave (
    output pad_data,
    input  pad_latch,
    input  pad_clk,
    input  buttons,
    input  val,
    input  frame_valid
  );
endinterface

// File: rtl/pad_sync.sv
// Two-flop synchronizer for the asynchronous pad data line.
// Resets to 1, which is the idle level (no button pressed).
module pad_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Two-stage resynchronization into the clk_i domain
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/nes_pad_reader.sv
// NES pad serial reader: periodic latch + 8 shift clocks, registers the
// active-high button vector and its priority-encoded display code.
// Optional macro PAD_DEBOUNCE_EN: only publish a frame that matches the
// previous raw frame.
module nes_pad_reader
  import pad_pkg::*;
#(
  parameter int unsigned HALF_CYCLES = 4,
  parameter int unsigned POLL_CYCLES = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  nes_pad_reader_if.master        bus
);

  localparam logic [CntW-1:0] PollLast  = CntW'(POLL_CYCLES - 1);
  localparam logic [CntW-1:0] LatchLast = CntW'(2 * HALF_CYCLES - 1);
  localparam logic [CntW-1:0] HalfLast  = CntW'(HALF_CYCLES - 1);

  pad_state_e      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            phase_q, phase_d;  // 0: pad_clk low half, 1: high half
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      buttons_q, buttons_d;
  logic [2:0]      val_q, val_d;
  logic            valid_q, valid_d;
`ifdef PAD_DEBOUNCE_EN
  logic [7:0]      prev_q, prev_d;
`endif

  logic            data_sync;
  logic [2:0]      val_enc;

  pad_sync u_pad_sync (
    .clk_i (clk),
    .rst_i (rst),
    .d_i   (bus.pad_data),
    .q_o   (data_sync)
  );

  // Priority encode the completed raw frame; Start has no code
  always_comb begin
    val_enc = VAL_NONE;
    if      (shift_q[BTN_A])      val_enc = VAL_A;
    else if (shift_q[BTN_B])      val_enc = VAL_B;
    else if (shift_q[BTN_SELECT]) val_enc = VAL_SELECT;
    else if (shift_q[BTN_UP])     val_enc = VAL_UP;
    else if (shift_q[BTN_DOWN])   val_enc = VAL_DOWN;
    else if (shift_q[BTN_LEFT])   val_enc = VAL_LEFT;
    else if (shift_q[BTN_RIGHT])  val_enc = VAL_RIGHT;
  end

  // State register and datapath registers; reset wins over everything
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      phase_q   <= 1'b0;
      idx_q     <= '0;
      shift_q   <= '0;
      buttons_q <= '0;
      val_q     <= VAL_NONE;
      valid_q   <= 1'b0;
`ifdef PAD_DEBOUNCE_EN
      prev_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      phase_q   <= phase_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      buttons_q <= buttons_d;
      val_q     <= val_d;
      valid_q   <= valid_d;
`ifdef PAD_DEBOUNCE_EN
      prev_q    <= prev_d;
`endif
    end
  end

  // Next-state logic: poll, latch, eight low/high bit slots, done
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + CntW'(1);
    phase_d   = phase_q;
    idx_d     = idx_q;
    shift_d   = shift_q;
    buttons_d = buttons_q;
    val_d     = val_q;
    valid_d   = 1'b0;
`ifdef PAD_DEBOUNCE_EN
    prev_d    = prev_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (cnt_q == PollLast) begin
          state_d = StLatch;
          cnt_d   = '0;
        end
      end
      StLatch: begin
        if (cnt_q == LatchLast) begin
          state_d = StRead;
          cnt_d   = '0;
          phase_d = 1'b0;
          idx_d   = '0;
        end
      end
      StRead: begin
        if (cnt_q == HalfLast) begin
          cnt_d = '0;
          if (!phase_q) begin
            // Last clock of the low half: data is active-low
            shift_d[idx_q] = ~data_sync;
            phase_d        = 1'b1;
          end else begin
            phase_d = 1'b0;
            if (idx_q == 3'd7) begin
              state_d = StDone;
              valid_d = 1'b1;
`ifdef PAD_DEBOUNCE_EN
              if (shift_q == prev_q) begin
                buttons_d = shift_q;
                val_d     = val_enc;
              end
              prev_d = shift_q;
`else
              buttons_d = shift_q;
              val_d     = val_enc;
`endif
            end else begin
              idx_d = idx_q + 3'd1;
            end
          end
        end
      end
      StDone: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  assign bus.pad_latch   = (state_q == StLatch);
  assign bus.pad_clk     = !((state_q == StRead) && !phase_q);
  assign bus.buttons     = buttons_q;
  assign bus.val         = val_q;
  assign bus.frame_valid = valid_q;

endmodule

// File: tb/tb_nes_pad_reader.sv
// Directed testbench for nes_pad_reader (H=4, POLL=10) with a behavioural pad.
module tb_nes_pad_reader;
  import pad_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  nes_pad_reader_if bus ();

  nes_pad_reader #(
    .HALF_CYCLES (4),
    .POLL_CYCLES (10)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int         checks = 0;
  int         errors = 0;
  int         valid_pulses = 0;
  logic [7:0] pressed = 8'h00;
  logic [7:0] pad_sr = 8'h00;
  logic       pclk_prev = 1'b1;

  initial bus.pad_data = 1'b1;

  // Pad model: parallel load while latched, shift on each pad_clk rise
  always @(negedge clk) begin
    if (bus.pad_latch) pad_sr = pressed;
    else if (bus.pad_clk && !pclk_prev) pad_sr = {1'b0, pad_sr[7:1]};
    pclk_prev    = bus.pad_clk;
    bus.pad_data = ~pad_sr[0];
  end

  // Count frame_valid pulses (sees the value of the cycle just ending)
  always @(posedge clk) begin
    if (bus.frame_valid) valid_pulses++;
  end

  // Cycles until pad_latch reads 1, starting at the next negedge; -1 on timeout
  task automatic count_to_latch(output int n);
    n = 0;
    forever begin
      @(negedge clk);
      if (bus.pad_latch) break;
      n++;
      if (n > 1000) begin
        n = -1;
        break;
      end
    end
  endtask

  // Called on the t=0 negedge; runs to frame_valid
  task automatic run_frame(output int t, output int lows, output logic [7:0] btn,
                           output logic [2:0] v);
    logic prev;
    t    = 0;
    lows = 0;
    btn  = 8'hxx;
    v    = 3'bxxx;
    prev = bus.pad_clk;
    forever begin
      @(negedge clk);
      t++;
      if (prev && !bus.pad_clk) lows++;
      prev = bus.pad_clk;
      if (bus.frame_valid) begin
        btn = bus.buttons;
        v   = bus.val;
        break;
      end
      if (t > 1000) begin
        t = -1;
        break;
      end
    end
  endtask

  task automatic one_frame(input logic [7:0] p, output int t, output int lows,
                           output logic [7:0] btn, output logic [2:0] v);
    int n;
    pressed = p;
    count_to_latch(n);
    run_frame(t, lows, btn, v);
  endtask

  // With debouncing a pattern must be seen twice before it is published
  task automatic settled_frame(input logic [7:0] p, output int t, output int lows,
                               output logic [7:0] btn, output logic [2:0] v);
`ifdef PAD_DEBOUNCE_EN
    one_frame(p, t, lows, btn, v);
`endif
    one_frame(p, t, lows, btn, v);
  endtask

  task automatic test_reset();
    int n;
    int w;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (bus.pad_latch !== 1'b0) begin errors++;
      $display("FAIL reset_latch: got %b want 0", bus.pad_latch); end
    checks++; if (bus.pad_clk !== 1'b1) begin errors++;
      $display("FAIL reset_pad_clk: got %b want 1", bus.pad_clk); end
    checks++; if (bus.buttons !== 8'h00) begin errors++;
      $display("FAIL reset_buttons: got %h want 00", bus.buttons); end
    checks++; if (bus.val !== VAL_NONE) begin errors++;
      $display("FAIL reset_val: got %b want 000", bus.val); end
    checks++; if (bus.frame_valid !== 1'b0) begin errors++;
      $display("FAIL reset_valid: got %b want 0", bus.frame_valid); end
    @(posedge clk);
    #1 rst = 1'b0;
    count_to_latch(n);
    checks++; if (n !== 10) begin errors++;
      $display("FAIL first_latch_delay: got %0d want 10", n); end
    w = 1;
    while (w < 100) begin
      @(negedge clk);
      if (!bus.pad_latch) break;
      w++;
    end
    checks++; if (w !== 8) begin errors++;
      $display("FAIL latch_width: got %0d want 8", w); end
  endtask

  task automatic test_a_only();
    int t, lows;
    logic [7:0] btn;
    logic [2:0] v;
    settled_frame(8'h01, t, lows, btn, v);
    checks++; if (t !== 72) begin errors++;
      $display("FAIL a_valid_time: got %0d want 72", t); end
    checks++; if (lows !== 8) begin errors++;
      $display("FAIL a_clk_pulses: got %0d want 8", lows); end
    checks++; if (btn !== 8'h01) begin errors++;
      $display("FAIL a_buttons: got %h want 01", btn); end
    checks++; if (v !== VAL_A) begin errors++;
      $display("FAIL a_val: got %b want 001", v); end
  endtask

  task automatic test_multi();
    int t, lows;
    logic [7:0] btn;
    logic [2:0] v;
    settled_frame(8'hB0, t, lows, btn, v);
    checks++; if (btn !== 8'hB0) begin errors++;
      $display("FAIL udr_buttons: got %h want b0", btn); end
    checks++; if (v !== VAL_UP) begin errors++;
      $display("FAIL udr_val: got %b want 100", v); end
    settled_frame(8'hC0, t, lows, btn, v);
    checks++; if (btn !== 8'hC0) begin errors++;
      $display("FAIL lr_buttons: got %h want c0", btn); end
    checks++; if (v !== VAL_LEFT) begin errors++;
      $display("FAIL lr_val: got %b want 110", v); end
  endtask

  task automatic test_start();
    int t, lows;
    logic [7:0] btn;
    logic [2:0] v;
    settled_frame(8'h08, t, lows, btn, v);
    checks++; if (btn !== 8'h08) begin errors++;
      $display("FAIL start_buttons: got %h want 08", btn); end
    checks++; if (v !== VAL_NONE) begin errors++;
      $display("FAIL start_val: got %b want 000", v); end
    settled_frame(8'h0C, t, lows, btn, v);
    checks++; if (btn !== 8'h0C) begin errors++;
      $display("FAIL start_sel_buttons: got %h want 0c", btn); end
    checks++; if (v !== VAL_SELECT) begin errors++;
      $display("FAIL start_sel_val: got %b want 011", v); end
  endtask

  task automatic test_reset_mid_frame();
    int n, t, lows, base;
    logic [7:0] btn;
    logic [2:0] v;
    pressed = 8'h02;
    count_to_latch(n);
    repeat (32) @(negedge clk);  // t=32: start of bit 3
    base = valid_pulses;
    rst  = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++; if (bus.pad_latch !== 1'b0) begin errors++;
      $display("FAIL midrst_latch: got %b want 0", bus.pad_latch); end
    checks++; if (bus.pad_clk !== 1'b1) begin errors++;
      $display("FAIL midrst_pad_clk: got %b want 1", bus.pad_clk); end
    checks++; if (bus.buttons !== 8'h00) begin errors++;
      $display("FAIL midrst_buttons: got %h want 00", bus.buttons); end
    checks++; if (bus.val !== VAL_NONE) begin errors++;
      $display("FAIL midrst_val: got %b want 000", bus.val); end
    // The cycle just checked is the first with rst low, so 9 more to latch
    count_to_latch(n);
    checks++; if (n !== 9) begin errors++;
      $display("FAIL midrst_latch_delay: got %0d want 9", n); end
    checks++; if (valid_pulses !== base) begin errors++;
      $display("FAIL midrst_no_valid: got %0d pulses want 0", valid_pulses - base); end
    run_frame(t, lows, btn, v);
`ifdef PAD_DEBOUNCE_EN
    one_frame(8'h02, t, lows, btn, v);
`endif
    checks++; if (t !== 72) begin errors++;
      $display("FAIL midrst_frame_time: got %0d want 72", t); end
    checks++; if (v !== VAL_B) begin errors++;
      $display("FAIL midrst_val_b: got %b want 010", v); end
  endtask

  task automatic test_frame_sequence();
    logic [7:0] pats [4];
    logic [2:0] expv [4];
    int t, lows, base;
    logic [7:0] btn;
    logic [2:0] v;
    pats = '{8'h02, 8'h00, 8'h02, 8'h02};
`ifdef PAD_DEBOUNCE_EN
    expv = '{VAL_NONE, VAL_NONE, VAL_NONE, VAL_B};
`else
    expv = '{VAL_B, VAL_NONE, VAL_B, VAL_B};
`endif
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    base = valid_pulses;
    for (int i = 0; i < 4; i++) begin
      one_frame(pats[i], t, lows, btn, v);
      checks++; if (v !== expv[i]) begin errors++;
        $display("FAIL seq_val[%0d]: got %b want %b", i, v, expv[i]); end
    end
    repeat (3) @(negedge clk);
    checks++; if (valid_pulses - base !== 4) begin errors++;
      $display("FAIL seq_valid_count: got %0d want 4", valid_pulses - base); end
  endtask

  initial begin
    test_reset();
    test_a_only();
    test_multi();
    test_start();
    test_reset_mid_frame();
    test_frame_sequence();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
